// File: rtl/bt_status_pkg.sv
// Shared constants, FSM encodings and packet helper
// for the Bluetooth status transmitter.
package bt_status_pkg;

  localparam logic [7:0] PKT_HDR    = 8'hA5;
  localparam logic [7:0] TYPE_TRACK = 8'h01;
  localparam logic [7:0] TYPE_VOL   = 8'h02;
  localparam logic [7:0] TYPE_HB    = 8'h03;
  localparam int         PKT_LEN    = 4;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_SEND,
    SEQ_DONE
  } seq_t;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_t;

  function automatic logic [7:0] pkt_byte(
    input logic [1:0] idx,
    input logic [7:0] typ,
    input logic [7:0] val
  );
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = PKT_HDR;
      2'd1:    b = typ;
      2'd2:    b = val;
      default: b = typ ^ val;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bt_status_tx_uart.sv
// 8N1 byte serialiser, LSB first; a start issued during the
// last stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
  import bt_status_pkg::*;
#(
  parameter int BAUD_DIV = 650
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(BAUD_DIV);

  bit_t          state;
  bit_t          state_n;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [9:0]    shreg;
  logic          tick;
  logic          load;

  assign tick = baud_cnt == CW'(BAUD_DIV - 1);
  assign txd  = shreg[0];
  assign busy = state != BIT_IDLE;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state)
      BIT_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = BIT_START;
        end
      end
      BIT_START: begin
        if (tick) state_n = BIT_DATA;
      end
      BIT_DATA: begin
        if (tick && bit_cnt == 3'd7) state_n = BIT_STOP;
      end
      BIT_STOP: begin
        if (tick) begin
          done = 1'b1;
          if (start) begin
            load    = 1'b1;
            state_n = BIT_START;
          end else begin
            state_n = BIT_IDLE;
          end
        end
      end
    endcase
  end

  // Ones shift in behind the frame, so the line idles high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= BIT_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else begin
      state <= state_n;
      if (load) begin
        shreg    <= {1'b1, data, 1'b0};
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (state != BIT_IDLE) begin
        if (tick) begin
          baud_cnt <= '0;
          shreg    <= {1'b1, shreg[9:1]};
          if (state == BIT_DATA) bit_cnt <= bit_cnt + 3'd1;
        end else begin
          baud_cnt <= baud_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bt_status_tx.sv
// Status packet sequencer for the reverse Bluetooth UART link.
// Optional heartbeat packets: define STATUS_HEARTBEAT_EN.
module bt_status_tx
  import bt_status_pkg::*;
#(
  parameter int BAUD_DIV  = 650,
  parameter int HB_PERIOD = 50000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] TRACK,
  input  logic [3:0] VOLUME,
  input  logic       PLAYING,
  input  logic       TRACK_EVT,
  input  logic       VOL_EVT,
  output logic       UART_TXD,
  output logic       BUSY,
  output logic       TX_DONE
);

  seq_t       seq;
  seq_t       seq_n;
  logic       trk_p;
  logic       vol_p;
  logic       hb_p;
  logic       launch;
  logic       sel_trk;
  logic       sel_vol;
  logic [7:0] typ_q;
  logic [7:0] val_q;
  logic [7:0] typ_n;
  logic [7:0] val_n;
  logic [1:0] idx_q;
  logic [1:0] idx_n;
  logic       start;
  logic [7:0] tx_data;
  logic       bdone;
  logic       byte_busy;
  logic       unused_sig;

  assign sel_trk = trk_p;
  assign sel_vol = !trk_p && vol_p;
  assign launch  = (seq == SEQ_IDLE) && (trk_p || vol_p || hb_p);
  assign BUSY    = seq == SEQ_SEND;
  assign TX_DONE = seq == SEQ_DONE;

`ifdef STATUS_HEARTBEAT_EN
  localparam int HW = $clog2(HB_PERIOD);

  logic [HW-1:0] hb_cnt;
  logic          hb_wrap;
  logic          sel_hb;

  assign hb_wrap    = hb_cnt == HW'(HB_PERIOD - 1);
  assign sel_hb     = !trk_p && !vol_p && hb_p;
  assign unused_sig = byte_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hb_cnt <= '0;
      hb_p   <= 1'b0;
    end else begin
      hb_cnt <= hb_wrap ? '0 : hb_cnt + HW'(1);
      hb_p   <= hb_wrap | (hb_p & !(launch & sel_hb));
    end
  end
`else
  assign hb_p       = 1'b0;
  assign unused_sig = byte_busy ^ PLAYING ^ (HB_PERIOD == 0);
`endif

  // Snapshot source for the packet about to launch.
  always_comb begin
    typ_n = TYPE_VOL;
    val_n = {4'b0, VOLUME};
    if (sel_trk) begin
      typ_n = TYPE_TRACK;
      val_n = {5'b0, TRACK};
    end
`ifdef STATUS_HEARTBEAT_EN
    else if (sel_hb) begin
      typ_n = TYPE_HB;
      val_n = {7'b0, PLAYING};
    end
`endif
  end

  always_comb begin
    seq_n   = seq;
    idx_n   = idx_q;
    start   = 1'b0;
    tx_data = PKT_HDR;
    unique case (seq)
      SEQ_IDLE: begin
        if (launch) begin
          seq_n = SEQ_SEND;
          idx_n = 2'd0;
          start = 1'b1;
        end
      end
      SEQ_SEND: begin
        if (bdone) begin
          if (idx_q == 2'(PKT_LEN - 1)) begin
            seq_n = SEQ_DONE;
          end else begin
            idx_n   = idx_q + 2'd1;
            start   = 1'b1;
            tx_data = pkt_byte(idx_q + 2'd1, typ_q, val_q);
          end
        end
      end
      SEQ_DONE: seq_n = SEQ_IDLE;
      default:  seq_n = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      seq   <= SEQ_IDLE;
      idx_q <= '0;
      typ_q <= '0;
      val_q <= '0;
      trk_p <= 1'b0;
      vol_p <= 1'b0;
    end else begin
      seq   <= seq_n;
      idx_q <= idx_n;
      if (launch) begin
        typ_q <= typ_n;
        val_q <= val_n;
      end
      trk_p <= TRACK_EVT | (trk_p & !(launch & sel_trk));
      vol_p <= VOL_EVT | (vol_p & !(launch & sel_vol));
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .CLK  (CLK),
    .RST  (RST),
    .start(start),
    .data (tx_data),
    .txd  (UART_TXD),
    .busy (byte_busy),
    .done (bdone)
  );

endmodule

// File: tb/tb_bt_status_tx.sv
// Directed bench for bt_status_tx: decodes the UART line mid-bit
// and checks packets, timing, coalescing and reset behaviour.
`timescale 1ns/1ps
module tb_bt_status_tx;

  localparam int BD = 4;
  localparam int HP = 1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] TRACK = '0;
  logic [3:0] VOLUME = '0;
  logic       PLAYING = 1'b1;
  logic       TRACK_EVT = 1'b0;
  logic       VOL_EVT = 1'b0;
  logic       UART_TXD;
  logic       BUSY;
  logic       TX_DONE;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  bt_status_tx #(
    .BAUD_DIV (BD),
    .HB_PERIOD(HP)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .TRACK    (TRACK),
    .VOLUME   (VOLUME),
    .PLAYING  (PLAYING),
    .TRACK_EVT(TRACK_EVT),
    .VOL_EVT  (VOL_EVT),
    .UART_TXD (UART_TXD),
    .BUSY     (BUSY),
    .TX_DONE  (TX_DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic trk, input logic vol);
    TRACK_EVT = trk;
    VOL_EVT   = vol;
    @(posedge CLK);
    #1;
    TRACK_EVT = 1'b0;
    VOL_EVT   = 1'b0;
  endtask

  task automatic rx_byte(input string tag,
                         input logic [7:0] exp,
                         output int t0);
    logic [7:0] b;
    int k;
    b  = '0;
    t0 = -1;
    k  = 0;
    @(negedge CLK);
    while (UART_TXD !== 1'b0 && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    if (UART_TXD !== 1'b0) begin
      check({tag, ".start"}, {31'b0, UART_TXD}, 32'd0);
      return;
    end
    t0 = cyc;
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge CLK);
      b[i] = UART_TXD;
    end
    repeat (BD) @(negedge CLK);
    check({tag, ".stop"}, {31'b0, UART_TXD}, 32'd1);
    check(tag, {24'b0, b}, {24'b0, exp});
  endtask

  task automatic rx_packet(input string tag,
                           input logic [7:0] typ,
                           input logic [7:0] val,
                           output int t0);
    int t;
    rx_byte({tag, ".hdr"}, 8'hA5, t0);
    rx_byte({tag, ".typ"}, typ, t);
    rx_byte({tag, ".val"}, val, t);
    rx_byte({tag, ".sum"}, typ ^ val, t);
  endtask

  task automatic wait_done(input string tag, output int td);
    int k;
    k  = 0;
    td = -1;
    @(negedge CLK);
    while (TX_DONE !== 1'b1 && k < 400) begin
      @(negedge CLK);
      k++;
    end
    check({tag, ".done"}, {31'b0, TX_DONE}, 32'd1);
    if (TX_DONE === 1'b1) begin
      td = cyc;
      check({tag, ".busy_at_done"}, {31'b0, BUSY}, 32'd0);
      @(negedge CLK);
      check({tag, ".done_pulse"}, {31'b0, TX_DONE}, 32'd0);
    end
  endtask

  task automatic idle_watch(input string tag, input int n);
    int bad;
    bad = 0;
    repeat (n) begin
      @(negedge CLK);
      if (UART_TXD !== 1'b1 || BUSY !== 1'b0 || TX_DONE !== 1'b0)
        bad++;
    end
    check(tag, bad, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, tl, td;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst.txd", {31'b0, UART_TXD}, 32'd1);
    check("rst.busy", {31'b0, BUSY}, 32'd0);
    check("rst.done", {31'b0, TX_DONE}, 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

`ifdef STATUS_HEARTBEAT_EN
    rx_packet("hb1", 8'h03, 8'h01, t0);
    rx_packet("hb2", 8'h03, 8'h01, t1);
    check("hb.period", t1 - t0, HP);
    while (cyc < t1 + 880) begin
      @(posedge CLK);
      #1;
    end
    TRACK = 3'd3;
    pulse(1'b1, 1'b0);
    fork
      rx_packet("hbp.trk", 8'h01, 8'h03, t0);
      begin
        tick(60);
        VOLUME = 4'd5;
        pulse(1'b0, 1'b1);
      end
    join
    rx_packet("hbp.vol", 8'h02, 8'h05, t0);
    rx_packet("hbp.hb", 8'h03, 8'h01, t0);
    wait_done("hbp", td);
`else
    tick(5);
    TRACK = 3'd5;
    pulse(1'b1, 1'b0);
    @(negedge CLK);
    check("t1.launch_txd", {31'b0, UART_TXD}, 32'd1);
    check("t1.launch_busy", {31'b0, BUSY}, 32'd0);
    tl = cyc;
    rx_packet("t1", 8'h01, 8'h05, t0);
    check("t1.start_lat", t0 - tl, 32'd1);
    check("t1.busy", {31'b0, BUSY}, 32'd1);
    wait_done("t1", td);
    check("t1.pkt_time", td - t0, 32'd160);

    tick(3);
    VOLUME = 4'd9;
    pulse(1'b0, 1'b1);
    rx_packet("t2a", 8'h02, 8'h09, t0);
    wait_done("t2a", td);

    tick(3);
    TRACK  = 3'd2;
    VOLUME = 4'd9;
    pulse(1'b1, 1'b1);
    rx_packet("t2b.trk", 8'h01, 8'h02, t0);
    rx_packet("t2b.vol", 8'h02, 8'h09, t1);
    check("t2b.gap", t1 - t0, 32'd162);
    wait_done("t2b", td);

    tick(3);
    TRACK = 3'd1;
    pulse(1'b1, 1'b0);
    fork
      rx_packet("t3.trk", 8'h01, 8'h01, t0);
      begin
        tick(20);
        VOLUME = 4'd3;
        pulse(1'b0, 1'b1);
        tick(30);
        VOLUME = 4'd7;
        pulse(1'b0, 1'b1);
      end
    join
    rx_packet("t3.vol", 8'h02, 8'h07, t0);
    wait_done("t3", td);
    idle_watch("t3.coalesce", 300);

    tick(2);
    TRACK  = 3'd6;
    VOLUME = 4'd4;
    pulse(1'b1, 1'b0);
    tick(50);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("t4.txd", {31'b0, UART_TXD}, 32'd1);
    check("t4.busy", {31'b0, BUSY}, 32'd0);
    check("t4.done", {31'b0, TX_DONE}, 32'd0);
    idle_watch("t4.abandon", 200);
    tick(1);
    pulse(1'b0, 1'b1);
    rx_packet("t4.vol", 8'h02, 8'h04, t0);
    wait_done("t4", td);

    idle_watch("t5.idle", 500);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
